run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Parametrised simulation run controller; successor to the single-reset simulation controller.
- Takes an external clock rather than generating one, so it works identically in event-driven and verilated benches.
- Provides:
  - a saturating cycle counter;
  - N staggered reset channels;
  - a loadable timeout;
  - an activity watchdog;
  - a drain-then-finish handshake with a sticky pass/fail status.
- Sits at testbench top, driving DUV reset domains and the bench finish logic.

Parameters:
CNT_W, 32, width of cycle counter and timeout.
CHANNELS, 4, number of reset output channels (1..16).
RST_CYCLES, 5, cycles before channel 0 reset release.
STAGGER_CYCLES, 2, extra release delay per channel index.
TIMEOUT, 10000, reset value of the timeout register.
WDOG_CYCLES, 1000, watchdog reload value; 0 disables the watchdog.
DRAIN_CYCLES, 8, cycles between accepted finish request and finish.
TICK_FREQ, 1000, progress tick period in cycles.

Ports:
run_ctrl_clk_ip  input  1  clock; single clock domain.
run_ctrl_rst_ip  input  1  asynchronous, active-high reset.
run_ctrl_rst_op  output CHANNELS  per-channel active-high reset.
run_ctrl_cycles_op  output CNT_W  cycles since reset release of the block.
run_ctrl_timeout_ip  input  CNT_W  new timeout value.
run_ctrl_timeout_ld_ip  input  1  load strobe for the timeout register.
run_ctrl_activity_ip  input  1  DUV heartbeat; reloads the watchdog.
run_ctrl_finish_req_ip  input  1  request orderly end of simulation.
run_ctrl_finish_op  output 1  sticky end-of-simulation flag.
run_ctrl_status_op  output 2  0 RUNNING, 1 PASS, 2 TIMEOUT, 3 WDOG.
run_ctrl_tick_op  output 1  one-cycle progress pulse.

Behaviour:
- Reset asserted, all outputs and state:
  - rst_op all 1s; cycles 0; finish 0; status 0; tick 0;
  - timeout_q = TIMEOUT; wdog_q = WDOG_CYCLES; state RELEASE; pend_q 0.
- Cycle counter: cyc_q += 1 every edge; saturates at 2^CNT_W-1; never wraps.
- Reset channels:
  - T_k = RST_CYCLES + k*STAGGER_CYCLES.
  - rst_op[k] == (cyc_q < T_k) at all times, implemented as a register (no glitches).
  - Once deasserted, a channel stays deasserted until block reset.
- Timeout register: timeout_ld_ip loads timeout_ip next edge, in any state.
- State machine, RELEASE → RUN → DRAIN → DONE:
  - RELEASE: goes to RUN on the edge where cyc_q reaches T_{CHANNELS-1}. finish_req here sets pend_q.
  - RUN:
    - priority 1: cyc_q > timeout_q → DONE, status TIMEOUT;
    - priority 2: WDOG_CYCLES != 0 and wdog_q == 0 → DONE, status WDOG;
    - priority 3: finish_req or pend_q → DRAIN, drain_q = DRAIN_CYCLES.
  - DRAIN:
    - timeout still checked (→ DONE, TIMEOUT); watchdog ignored;
    - drain_q decrements each cycle; at 0 → DONE, status PASS.
    - DRAIN_CYCLES = 0 gives DONE on the next edge.
  - DONE: finish_op = 1 and status held until reset. All inputs ignored; counter keeps running.
- Timeout in RELEASE: same compare; → DONE with status TIMEOUT.
- Watchdog counter (RUN only):
  - activity_ip reloads wdog_q to WDOG_CYCLES;
  - otherwise decrements, saturating at 0.
  - Activity and expiry in the same cycle: activity wins (no WDOG).
- Latency:
  - finish_req sampled in RUN at edge n → finish_op high after edge n + 1 + DRAIN_CYCLES.
  - Timeout: finish_op rises on the edge after cyc_q first exceeds timeout_q.
- Reset mid-operation: asynchronous return to the reset values above, from any state including DONE.

Optional Feature:
RUN_CTRL_PROGRESS_EN:
- Defined:
  - tick_op pulses for one cycle when cyc_q % TICK_FREQ == 0 and cyc_q != 0;
  - on each tick, the standard information message prints the cycle count;
  - on entry to DONE, the standard message prints the status name and cycle count.
- Undefined: tick_op tied 0; no messages; the port stays present.

Decomposition:
- run_ctrl_pkg holds:
  - state enum (RELEASE, RUN, DRAIN, DONE);
  - status enum codes (RUNNING=0, PASS=1, TIMEOUT=2, WDOG=3);
  - a function computing T_k.
- Sub-module run_ctrl_rst_seq: generate-loop of CHANNELS release comparators and registers. It takes cyc_q and produces rst_op.

Test Plan:
- Default parameters, CHANNELS=4, reset low at edge 0 → rst_op releases at cycles 5, 7, 9, 11; RUN entered at cycle 11.
- finish_req pulse at cycle 20, DRAIN_CYCLES=8 → finish_op high after edge 29; status 1. A further finish_req has no effect.
- Load timeout 30 at cycle 12, no finish → finish_op rises when cyc_q goes 31→32; status 2.
- WDOG_CYCLES=10, activity every 5 cycles to cycle 40, then silent → status 3 at cycle 51. Activity at the expiry cycle prevents WDOG.
- finish_req at cycle 3 (RELEASE) → latched; DRAIN starts at cycle 11; finish at 20.
- Reset asserted at cycle 25 in DRAIN → all outputs return to reset values asynchronously. The sequence restarts cleanly after release.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run controller: FSM states, status codes
// and the per-channel reset release cycle.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_RUNNING = 2'd0,
    STAT_PASS    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_WDOG    = 2'd3
  } status_e;

  // Cycle at which reset channel k is released.
  function automatic int release_cycle(input int rst_cycles, input int stagger, input int k);
    return rst_cycles + k * stagger;
  endfunction

endpackage

// File: rtl/run_ctrl_rst_seq.sv
// Staggered reset channels: channel k is high while the cycle count is below
// its release cycle, registered from the next count so the output never glitches.
module run_ctrl_rst_seq
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int CHANNELS       = 4,
  parameter int RST_CYCLES     = 5,
  parameter int STAGGER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    cyc,
  output logic [CHANNELS-1:0] chan_rst
);

  logic [CNT_W-1:0] cyc_next;

  assign cyc_next = (cyc == '1) ? cyc : cyc + CNT_W'(1);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    localparam logic [63:0] T_K = 64'(release_cycle(RST_CYCLES, STAGGER_CYCLES, k));

    // Sticky release: once low, only the block reset raises it again.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) chan_rst[k] <= 1'b1;
      else     chan_rst[k] <= chan_rst[k] & (64'(cyc_next) < T_K);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Simulation run controller: cycle counter, staggered resets, timeout, watchdog
// and drain-then-finish. Progress ticks/messages are enabled by RUN_CTRL_PROGRESS_EN.
//
// state      | meaning
// RELEASE    | reset channels still releasing; finish requests are latched
// RUN        | normal operation; timeout, watchdog and finish requests checked
// DRAIN      | finish accepted, counting down DRAIN_CYCLES; timeout still checked
// DONE       | finish and status held until reset
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int CHANNELS       = 4,
  parameter int RST_CYCLES     = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int TIMEOUT        = 10000,
  parameter int WDOG_CYCLES    = 1000,
  parameter int DRAIN_CYCLES   = 8,
  parameter int TICK_FREQ      = 1000
) (
  input  logic                run_ctrl_clk_ip,
  input  logic                run_ctrl_rst_ip,
  output logic [CHANNELS-1:0] run_ctrl_rst_op,
  output logic [CNT_W-1:0]    run_ctrl_cycles_op,
  input  logic [CNT_W-1:0]    run_ctrl_timeout_ip,
  input  logic                run_ctrl_timeout_ld_ip,
  input  logic                run_ctrl_activity_ip,
  input  logic                run_ctrl_finish_req_ip,
  output logic                run_ctrl_finish_op,
  output logic [1:0]          run_ctrl_status_op,
  output logic                run_ctrl_tick_op
);

  localparam logic [63:0]      T_LAST       = 64'(release_cycle(RST_CYCLES, STAGGER_CYCLES, CHANNELS - 1));
  localparam logic [CNT_W-1:0] TIMEOUT_INIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WDOG_RELOAD  = CNT_W'(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_INIT   = CNT_W'(DRAIN_CYCLES);
  localparam bit               WDOG_EN      = (WDOG_CYCLES != 0);

  if (CHANNELS < 1 || CHANNELS > 16 || TICK_FREQ < 1) begin : g_param_check
    $error("run_ctrl: CHANNELS must be 1..16 and TICK_FREQ at least 1");
  end

  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W-1:0] timeout_q;
  logic [CNT_W-1:0] wdog_q;
  logic [CNT_W-1:0] drain_q;
  state_e           state_q;
  status_e          status_q;
  logic             finish_q;
  logic             pend_q;

  assign cyc_next = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);

  always_ff @(posedge run_ctrl_clk_ip or posedge run_ctrl_rst_ip) begin
    if (run_ctrl_rst_ip) cyc_q <= '0;
    else                 cyc_q <= cyc_next;
  end

  always_ff @(posedge run_ctrl_clk_ip or posedge run_ctrl_rst_ip) begin
    if (run_ctrl_rst_ip)             timeout_q <= TIMEOUT_INIT;
    else if (run_ctrl_timeout_ld_ip) timeout_q <= run_ctrl_timeout_ip;
  end

  run_ctrl_rst_seq #(
    .CNT_W          (CNT_W),
    .CHANNELS       (CHANNELS),
    .RST_CYCLES     (RST_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES)
  ) u_rst_seq (
    .clk      (run_ctrl_clk_ip),
    .rst      (run_ctrl_rst_ip),
    .cyc      (cyc_q),
    .chan_rst (run_ctrl_rst_op)
  );

  always_ff @(posedge run_ctrl_clk_ip or posedge run_ctrl_rst_ip) begin
    if (run_ctrl_rst_ip) begin
      state_q  <= ST_RELEASE;
      status_q <= STAT_RUNNING;
      finish_q <= 1'b0;
      pend_q   <= 1'b0;
      wdog_q   <= WDOG_RELOAD;
      drain_q  <= '0;
    end else begin
      case (state_q)
        ST_RELEASE: begin
          if (cyc_q > timeout_q) begin
            state_q  <= ST_DONE;
            status_q <= STAT_TIMEOUT;
            finish_q <= 1'b1;
          end else if (64'(cyc_next) >= T_LAST) begin
            // A latched request skips RUN so draining starts on the release edge.
            pend_q <= 1'b0;
            if (pend_q || run_ctrl_finish_req_ip) begin
              state_q <= ST_DRAIN;
              drain_q <= DRAIN_INIT;
            end else begin
              state_q <= ST_RUN;
            end
          end else if (run_ctrl_finish_req_ip) begin
            pend_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cyc_q > timeout_q) begin
            state_q  <= ST_DONE;
            status_q <= STAT_TIMEOUT;
            finish_q <= 1'b1;
          end else if (WDOG_EN && wdog_q == '0 && !run_ctrl_activity_ip) begin
            state_q  <= ST_DONE;
            status_q <= STAT_WDOG;
            finish_q <= 1'b1;
          end else begin
            if (run_ctrl_finish_req_ip || pend_q) begin
              state_q <= ST_DRAIN;
              drain_q <= DRAIN_INIT;
              pend_q  <= 1'b0;
            end
            if (run_ctrl_activity_ip) wdog_q <= WDOG_RELOAD;
            else if (wdog_q != '0)    wdog_q <= wdog_q - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cyc_q > timeout_q) begin
            state_q  <= ST_DONE;
            status_q <= STAT_TIMEOUT;
            finish_q <= 1'b1;
          end else if (drain_q == '0) begin
            state_q  <= ST_DONE;
            status_q <= STAT_PASS;
            finish_q <= 1'b1;
          end else begin
            drain_q <= drain_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_DONE;
        end
      endcase
    end
  end

  assign run_ctrl_cycles_op = cyc_q;
  assign run_ctrl_finish_op = finish_q;
  assign run_ctrl_status_op = status_q;

`ifdef RUN_CTRL_PROGRESS_EN
  localparam logic [CNT_W-1:0] TICK_PERIOD = CNT_W'(TICK_FREQ);

  logic tick_q;
  logic done_seen_q;

  // Tick is registered from the next count; a saturated counter stops ticking.
  always_ff @(posedge run_ctrl_clk_ip or posedge run_ctrl_rst_ip) begin
    if (run_ctrl_rst_ip) begin
      tick_q      <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      tick_q      <= (cyc_next != cyc_q) && (cyc_next % TICK_PERIOD == '0);
      done_seen_q <= (state_q == ST_DONE);
    end
  end

  always @(posedge run_ctrl_clk_ip) begin
    if (!run_ctrl_rst_ip && tick_q)
      $info("run_ctrl: cycle %0d", cyc_q);
    if (!run_ctrl_rst_ip && state_q == ST_DONE && !done_seen_q)
      $info("run_ctrl: finished with status %s at cycle %0d", status_q.name(), cyc_q);
  end

  assign run_ctrl_tick_op = tick_q;
`else
  assign run_ctrl_tick_op = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with a narrow counter and a short
// watchdog so saturation and watchdog expiry are reachable quickly.
module tb_run_ctrl;

  localparam int CNT_W    = 8;
  localparam int CHANNELS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CHANNELS-1:0] rst_chan;
  logic [CNT_W-1:0]    cycles;
  logic [CNT_W-1:0]    timeout_val = '0;
  logic                timeout_ld = 1'b0;
  logic                activity = 1'b0;
  logic                finish_req = 1'b0;
  logic                finish;
  logic [1:0]          status;
  logic                tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_ctrl #(
    .CNT_W          (CNT_W),
    .CHANNELS       (CHANNELS),
    .RST_CYCLES     (5),
    .STAGGER_CYCLES (2),
    .TIMEOUT        (200),
    .WDOG_CYCLES    (10),
    .DRAIN_CYCLES   (8),
    .TICK_FREQ      (10)
  ) dut (
    .run_ctrl_clk_ip        (clk),
    .run_ctrl_rst_ip        (rst),
    .run_ctrl_rst_op        (rst_chan),
    .run_ctrl_cycles_op     (cycles),
    .run_ctrl_timeout_ip    (timeout_val),
    .run_ctrl_timeout_ld_ip (timeout_ld),
    .run_ctrl_activity_ip   (activity),
    .run_ctrl_finish_req_ip (finish_req),
    .run_ctrl_finish_op     (finish),
    .run_ctrl_status_op     (status),
    .run_ctrl_tick_op       (tick)
  );

  task automatic do_reset();
    rst        = 1'b1;
    timeout_ld = 1'b0;
    finish_req = 1'b0;
    activity   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the negedge where the cycle count equals n (bounded).
  task automatic step_to(input int n);
    int guard = 0;
    while (int'(cycles) != n && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (int'(cycles) != n) begin
      errors++;
      checks++;
      $display("FAIL step_to: cycles=%0d required %0d", cycles, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (rst_chan !== 4'hF) begin errors++; $display("FAIL reset_rst: got %h want f", rst_chan); end
    checks++; if (cycles !== 8'd0)   begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    checks++; if (finish !== 1'b0)   begin errors++; $display("FAIL reset_finish: got %b want 0", finish); end
    checks++; if (status !== 2'd0)   begin errors++; $display("FAIL reset_status: got %0d want 0", status); end
    checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_release();
    logic [CHANNELS-1:0] exp;
    do_reset();
    activity = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step_to(c);
      for (int k = 0; k < CHANNELS; k++) exp[k] = (c < 5 + 2 * k);
      checks++;
      if (rst_chan !== exp) begin
        errors++;
        $display("FAIL release_c%0d: got %b want %b", c, rst_chan, exp);
      end
    end
  endtask

  task automatic test_finish();
    do_reset();
    activity = 1'b1;
    step_to(19); finish_req = 1'b1;
    step_to(20); finish_req = 1'b0;
    step_to(28);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL finish_early: got %b want 0", finish); end
    step_to(29);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL finish_rise: got %b want 1", finish); end
    checks++; if (status !== 2'd1) begin errors++; $display("FAIL finish_status: got %0d want 1", status); end
    step_to(31); finish_req = 1'b1; activity = 1'b0;
    step_to(32); finish_req = 1'b0;
    step_to(40);
    checks++; if (finish !== 1'b1 || status !== 2'd1) begin
      errors++; $display("FAIL finish_sticky: got finish=%b status=%0d want 1/1", finish, status);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    activity = 1'b1;
    step_to(11); timeout_val = 8'd30; timeout_ld = 1'b1;
    step_to(12); timeout_ld = 1'b0;
    step_to(31);
    checks++; if (finish !== 1'b0 || status !== 2'd0) begin
      errors++; $display("FAIL timeout_early: got finish=%b status=%0d want 0/0", finish, status);
    end
    step_to(32);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL timeout_rise: got %b want 1", finish); end
    checks++; if (status !== 2'd2) begin errors++; $display("FAIL timeout_status: got %0d want 2", status); end
  endtask

  task automatic test_timeout_release();
    do_reset();
    timeout_val = 8'd3; timeout_ld = 1'b1;
    step_to(1); timeout_ld = 1'b0;
    step_to(4);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rel_timeout_early: got %b want 0", finish); end
    step_to(5);
    checks++; if (finish !== 1'b1 || status !== 2'd2) begin
      errors++; $display("FAIL rel_timeout: got finish=%b status=%0d want 1/2", finish, status);
    end
    checks++; if (rst_chan !== 4'b1110) begin errors++; $display("FAIL rel_timeout_rst: got %b want 1110", rst_chan); end
  endtask

  task automatic test_wdog();
    do_reset();
    for (int c = 14; c <= 39; c += 5) begin
      step_to(c); activity = 1'b1;
      step_to(c + 1); activity = 1'b0;
    end
    step_to(50);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b want 0", finish); end
    step_to(51);
    checks++; if (finish !== 1'b1 || status !== 2'd3) begin
      errors++; $display("FAIL wdog_expire: got finish=%b status=%0d want 1/3", finish, status);
    end
  endtask

  task automatic test_wdog_activity_wins();
    do_reset();
    for (int c = 14; c <= 39; c += 5) begin
      step_to(c); activity = 1'b1;
      step_to(c + 1); activity = 1'b0;
    end
    step_to(50); activity = 1'b1;
    step_to(51); activity = 1'b0;
    checks++; if (finish !== 1'b0 || status !== 2'd0) begin
      errors++; $display("FAIL wdog_act_wins: got finish=%b status=%0d want 0/0", finish, status);
    end
    step_to(61);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL wdog_reload_early: got %b want 0", finish); end
    step_to(62);
    checks++; if (finish !== 1'b1 || status !== 2'd3) begin
      errors++; $display("FAIL wdog_reload_expire: got finish=%b status=%0d want 1/3", finish, status);
    end
  endtask

  task automatic test_pending();
    do_reset();
    activity = 1'b1;
    step_to(2); finish_req = 1'b1;
    step_to(3); finish_req = 1'b0;
    step_to(19);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL pend_early: got %b want 0", finish); end
    step_to(20);
    checks++; if (finish !== 1'b1 || status !== 2'd1) begin
      errors++; $display("FAIL pend_finish: got finish=%b status=%0d want 1/1", finish, status);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    activity = 1'b1;
    step_to(19); finish_req = 1'b1;
    step_to(20); finish_req = 1'b0;
    step_to(25);
    #2 rst = 1'b1;
    #1;
    checks++; if (rst_chan !== 4'hF || cycles !== 8'd0 || finish !== 1'b0 || status !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: got rst=%h cycles=%0d finish=%b status=%0d want f/0/0/0",
               rst_chan, cycles, finish, status);
    end
    @(negedge clk);
    rst = 1'b0;
    step_to(4);
    checks++; if (rst_chan !== 4'hF) begin errors++; $display("FAIL restart_c4: got %b want 1111", rst_chan); end
    step_to(5);
    checks++; if (rst_chan !== 4'hE) begin errors++; $display("FAIL restart_c5: got %b want 1110", rst_chan); end
    step_to(19); finish_req = 1'b1;
    step_to(20); finish_req = 1'b0;
    step_to(28);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL restart_early: got %b want 0", finish); end
    step_to(29);
    checks++; if (finish !== 1'b1 || status !== 2'd1) begin
      errors++; $display("FAIL restart_finish: got finish=%b status=%0d want 1/1", finish, status);
    end
  endtask

  task automatic test_tick();
    logic exp_tick;
`ifdef RUN_CTRL_PROGRESS_EN
    exp_tick = 1'b1;
`else
    exp_tick = 1'b0;
`endif
    do_reset();
    activity = 1'b1;
    step_to(9);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_c9: got %b want 0", tick); end
    step_to(10);
    checks++; if (tick !== exp_tick) begin errors++; $display("FAIL tick_c10: got %b want %b", tick, exp_tick); end
    step_to(11);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_c11: got %b want 0", tick); end
  endtask

  task automatic test_saturate();
    do_reset();
    activity = 1'b1;
    timeout_val = 8'hFF; timeout_ld = 1'b1;
    step_to(1); timeout_ld = 1'b0;
    repeat (270) @(negedge clk);
    checks++; if (cycles !== 8'hFF) begin errors++; $display("FAIL saturate: got %0d want 255", cycles); end
    checks++; if (finish !== 1'b0 || rst_chan !== 4'h0) begin
      errors++; $display("FAIL saturate_state: got finish=%b rst=%h want 0/0", finish, rst_chan);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_finish();
    test_timeout();
    test_timeout_release();
    test_wdog();
    test_wdog_activity_wins();
    test_pending();
    test_mid_reset();
    test_tick();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
